sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, clock cycles each SRAM half-word phase is held (legal 1..15).
REQ-002 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-004 SHALL have port req  input  1  CPU access request, sampled in IDLE only.
REQ-005 SHALL have port we  input  1  1=write, 0=read, latched with req.
REQ-006 SHALL have port cpu_addr  input  17  32-bit word address.
REQ-007 SHALL have port cpu_be  input  4  byte enables: bit0=byte 0 (low half, low byte) .. bit3=byte 3.
REQ-008 SHALL have port cpu_wdata  input  32  write data, latched with req.
REQ-009 SHALL have port cpu_rdata  output  32  read data, valid while ready=1.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port addr  output  18  SRAM half-word address.
REQ-012 SHALL have port data  inout  16  SRAM data bus.
REQ-013 SHALL have ports wre, oute, hb_mask, lb_mask, chip_en  output  1 each  SRAM strobes, all active-low.

Function
REQ-014 SHALL implement states IDLE, LO, HI, DONE; IDLE->LO on req=1; LO->HI and HI->DONE after WAIT_CYCLES cycles; DONE->IDLE unconditionally.
REQ-015 SHALL latch we, cpu_addr, cpu_be, cpu_wdata on the IDLE cycle where req=1; inputs ignored in every other state.
REQ-016 SHALL drive addr={cpu_addr,1'b0} in LO and {cpu_addr,1'b1} in HI; addr holds last value otherwise.
REQ-017 SHALL assert chip_en=0 only in LO/HI; wre=0 only in LO/HI of a write; oute=0 only in LO/HI of a read.
REQ-018 SHALL drive lb_mask=~be[0], hb_mask=~be[1] in LO and lb_mask=~be[2], hb_mask=~be[3] in HI; both 1 in IDLE/DONE.
REQ-019 SHALL drive data=wdata[15:0] in LO and wdata[31:16] in HI of a write only; data SHALL be high-Z at all other times.
REQ-020 SHALL capture data into cpu_rdata[15:0] on the last LO cycle and cpu_rdata[31:16] on the last HI cycle of a read; cpu_rdata holds until the next read capture.
REQ-021 SHALL assert ready=1 exactly in DONE; latency req-sample to ready = 2*WAIT_CYCLES+1 cycles (3 at default).
REQ-022 SHALL not accept req in DONE; back-to-back requests incur one IDLE cycle between ready and next LO.
REQ-023 SHALL leave disabled byte lanes of cpu_rdata at captured bus value (no zeroing).

Reset
REQ-024 SHALL on reset=0 immediately force IDLE, ready=0, cpu_rdata=0, addr=0, wre=oute=chip_en=hb_mask=lb_mask=1, data high-Z, including mid-access.
REQ-025 SHALL resume after reset release with the first req sampled on the first rising edge with reset=1.

Configuration
REQ-026 SHALL recognise macro SRAM_CTRL_HALF_SKIP_EN.
REQ-027 SHALL, with SRAM_CTRL_HALF_SKIP_EN defined, skip LO when be[1:0]=0 and HI when be[3:2]=0 (be=0 goes IDLE->DONE, latency 1); skipped half of cpu_rdata is unchanged.
REQ-028 SHALL, without the macro, always execute both phases, with masks both 1 for a half whose enables are zero.

Verification
REQ-029 SHALL verify: write we=1 addr=17'h00012 be=F wdata=32'hDEADBEEF -> LO addr=18'h00024 data=16'hBEEF wre=0, HI addr=18'h00025 data=16'hDEAD, ready at cycle 3.
REQ-030 SHALL verify: read of same address with SRAM model returning stored halves -> cpu_rdata=32'hDEADBEEF while ready=1, oute=0 in LO/HI, data never driven by block.
REQ-031 SHALL verify: write be=4'b0100 wdata=32'h00AA0000 -> HI lb_mask=0 hb_mask=1; LO both masks 1 (macro off) or LO absent with ready at cycle 2 (macro on).
REQ-032 SHALL verify: WAIT_CYCLES=3 read -> each phase 3 cycles, ready at cycle 7; req held high continuously -> second access LO starts one cycle after ready.
REQ-033 SHALL verify: reset=0 asserted during HI of a write -> same-cycle chip_en=wre=1, data high-Z, ready never pulses; next req after release completes normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// 32-bit CPU to 16-bit asynchronous SRAM bridge: each word access runs as a low then a high half-word phase.
// Optional build macro SRAM_CTRL_HALF_SKIP_EN skips a phase whose two byte enables are both clear.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [16:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ready,
    output logic [17:0] addr,
    inout  tri   [15:0] data,
    output logic        wre,
    output logic        oute,
    output logic        hb_mask,
    output logic        lb_mask,
    output logic        chip_en
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        phase_end;

    logic        we_q;
    logic [16:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [16:0] addr_src;

    logic        skip_lo_req;
    logic        skip_hi_req;
    logic        skip_hi_q;

    logic        drive_en;
    logic [15:0] dout;

`ifdef SRAM_CTRL_HALF_SKIP_EN
    assign skip_lo_req = ~|cpu_be[1:0];
    assign skip_hi_req = ~|cpu_be[3:2];
    assign skip_hi_q   = ~|be_q[3:2];
`else
    assign skip_lo_req = 1'b0;
    assign skip_hi_req = 1'b0;
    assign skip_hi_q   = 1'b0;
`endif

    assign phase_end = (cnt == LAST);

    // The phase entered straight from IDLE must use the live address, not the not-yet-latched copy.
    assign addr_src = (state == IDLE) ? cpu_addr : addr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!skip_lo_req) begin
                        next_state = LO;
                    end else if (!skip_hi_req) begin
                        next_state = HI;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            LO: begin
                if (phase_end) begin
                    next_state = skip_hi_q ? DONE : HI;
                end
            end
            HI: begin
                if (phase_end) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        chip_en  = 1'b1;
        wre      = 1'b1;
        oute     = 1'b1;
        lb_mask  = 1'b1;
        hb_mask  = 1'b1;
        ready    = 1'b0;
        drive_en = 1'b0;
        dout     = '0;
        case (state)
            LO: begin
                chip_en  = 1'b0;
                wre      = ~we_q;
                oute     = we_q;
                lb_mask  = ~be_q[0];
                hb_mask  = ~be_q[1];
                drive_en = we_q;
                dout     = wdata_q[15:0];
            end
            HI: begin
                chip_en  = 1'b0;
                wre      = ~we_q;
                oute     = we_q;
                lb_mask  = ~be_q[2];
                hb_mask  = ~be_q[3];
                drive_en = we_q;
                dout     = wdata_q[31:16];
            end
            DONE: ready = 1'b1;
            default: ;
        endcase
    end

    assign data = drive_en ? dout : 'z;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (state == LO || state == HI) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= cpu_addr;
            be_q    <= cpu_be;
            wdata_q <= cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (next_state == LO) begin
            addr <= {addr_src, 1'b0};
        end else if (next_state == HI) begin
            addr <= {addr_src, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rdata <= '0;
        end else if (!we_q && phase_end) begin
            if (state == LO) begin
                cpu_rdata[15:0] <= data;
            end else if (state == HI) begin
                cpu_rdata[31:16] <= data;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default instance plus a WAIT_CYCLES=3 instance, each on its own SRAM model.
// Expectations follow SRAM_CTRL_HALF_SKIP_EN when the bench is built with that macro.
module tb_sram_ctrl;

    logic        clock;
    logic        reset;

    logic        req, we;
    logic [16:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ready, wre, oute, hb_mask, lb_mask, chip_en;
    logic [17:0] addr;
    tri1  [15:0] data;

    logic        req3, we3;
    logic [16:0] cpu_addr3;
    logic [3:0]  cpu_be3;
    logic [31:0] cpu_wdata3, cpu_rdata3;
    logic        ready3, wre3, oute3, hb_mask3, lb_mask3, chip_en3;
    logic [17:0] addr3;
    tri1  [15:0] data3;

    logic [15:0] mem  [256];
    logic [15:0] mem3 [256];

    int checks = 0;
    int failures = 0;
    int ready_pulses = 0;

    sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ready(ready),
        .addr(addr), .data(data), .wre(wre), .oute(oute), .hb_mask(hb_mask),
        .lb_mask(lb_mask), .chip_en(chip_en)
    );

    sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .req(req3), .we(we3), .cpu_addr(cpu_addr3),
        .cpu_be(cpu_be3), .cpu_wdata(cpu_wdata3), .cpu_rdata(cpu_rdata3), .ready(ready3),
        .addr(addr3), .data(data3), .wre(wre3), .oute(oute3), .hb_mask(hb_mask3),
        .lb_mask(lb_mask3), .chip_en(chip_en3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-masked asynchronous SRAM models; an undriven bus floats to all ones.
    assign data  = (!chip_en  && !oute)  ? mem[addr[7:0]]   : 'z;
    assign data3 = (!chip_en3 && !oute3) ? mem3[addr3[7:0]] : 'z;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  <= '0;
            mem3[i] <= '0;
        end
        mem[8'h60]  <= 16'h3333;
        mem[8'h61]  <= 16'h5555;
        mem3[8'h24] <= 16'h1111;
        mem3[8'h25] <= 16'h2222;
    end

    always @(posedge clock) begin
        if (!chip_en && !wre) begin
            if (!lb_mask) mem[addr[7:0]][7:0]  <= data[7:0];
            if (!hb_mask) mem[addr[7:0]][15:8] <= data[15:8];
        end
        if (!chip_en3 && !wre3) begin
            if (!lb_mask3) mem3[addr3[7:0]][7:0]  <= data3[7:0];
            if (!hb_mask3) mem3[addr3[7:0]][15:8] <= data3[15:8];
        end
        if (ready === 1'b1) ready_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clock);
    endtask

    // Presents one request for a single cycle, then scrambles the inputs to show they are ignored.
    task automatic issue(input logic w, input logic [16:0] a, input logic [3:0] b, input logic [31:0] d);
        we = w; cpu_addr = a; cpu_be = b; cpu_wdata = d; req = 1'b1;
        cyc();
        req = 1'b0; we = ~w; cpu_addr = '1; cpu_be = '0; cpu_wdata = 32'h0F0F0F0F;
    endtask

    initial begin
        reset = 1'b0;
        req = 1'b0; we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        req3 = 1'b0; we3 = 1'b0; cpu_addr3 = '0; cpu_be3 = '0; cpu_wdata3 = '0;

        #2;
        check("rst_ready", ready, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_addr", addr, 0);
        check("rst_strobes", {chip_en, wre, oute, hb_mask, lb_mask}, 5'b11111);
        check("rst_data_z", data, 16'hFFFF);

        cyc();
        reset = 1'b1;

        // Full-word write
        issue(1'b1, 17'h00012, 4'hF, 32'hDEADBEEF);
        check("w_lo_addr", addr, 18'h00024);
        check("w_lo_data", data, 16'hBEEF);
        check("w_lo_strobes", {chip_en, wre, oute, hb_mask, lb_mask}, 5'b00100);
        check("w_lo_ready", ready, 0);
        cyc();
        check("w_hi_addr", addr, 18'h00025);
        check("w_hi_data", data, 16'hDEAD);
        check("w_hi_wre", wre, 0);
        check("w_hi_ready", ready, 0);
        cyc();
        check("w_done_ready", ready, 1);
        check("w_done_strobes", {chip_en, wre, oute}, 3'b111);
        check("w_done_data_z", data, 16'hFFFF);
        check("w_done_addr_hold", addr, 18'h00025);
        cyc();
        check("w_idle_ready", ready, 0);

        // Read back the same word
        issue(1'b0, 17'h00012, 4'hF, 32'h12345678);
        check("r_lo_strobes", {chip_en, wre, oute}, 3'b010);
        check("r_lo_addr", addr, 18'h00024);
        check("r_lo_bus", data, 16'hBEEF);
        cyc();
        check("r_hi_oute", oute, 0);
        check("r_hi_bus", data, 16'hDEAD);
        cyc();
        check("r_done_ready", ready, 1);
        check("r_done_rdata", cpu_rdata, 32'hDEADBEEF);
        check("r_done_data_z", data, 16'hFFFF);
        cyc();
        check("r_idle_ready", ready, 0);
        check("r_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // Single-byte write to byte 2
        issue(1'b1, 17'h00030, 4'b0100, 32'h00AA0000);
`ifdef SRAM_CTRL_HALF_SKIP_EN
        check("b2_hi_addr", addr, 18'h00061);
        check("b2_hi_masks", {hb_mask, lb_mask}, 2'b10);
        check("b2_hi_data", data, 16'h00AA);
        check("b2_hi_ready", ready, 0);
        cyc();
        check("b2_done_ready", ready, 1);
`else
        check("b2_lo_addr", addr, 18'h00060);
        check("b2_lo_masks", {hb_mask, lb_mask}, 2'b11);
        check("b2_lo_en", {chip_en, wre}, 2'b00);
        cyc();
        check("b2_hi_addr", addr, 18'h00061);
        check("b2_hi_masks", {hb_mask, lb_mask}, 2'b10);
        check("b2_hi_data", data, 16'h00AA);
        check("b2_hi_ready", ready, 0);
        cyc();
        check("b2_done_ready", ready, 1);
`endif
        cyc();
        issue(1'b0, 17'h00030, 4'hF, 32'h0);
        cyc();
        cyc();
        check("b2_readback", cpu_rdata, 32'h55AA3333);
        cyc();

        // Read with only byte 0 enabled; disabled lanes keep whatever was captured
        issue(1'b0, 17'h00012, 4'b0001, 32'h0);
        check("b0_lo_masks", {hb_mask, lb_mask}, 2'b10);
`ifdef SRAM_CTRL_HALF_SKIP_EN
        cyc();
        check("b0_done_ready", ready, 1);
        check("b0_rdata", cpu_rdata, 32'h55AABEEF);
`else
        cyc();
        check("b0_hi_masks", {hb_mask, lb_mask}, 2'b11);
        cyc();
        check("b0_done_ready", ready, 1);
        check("b0_rdata", cpu_rdata, 32'hDEADBEEF);
`endif
        cyc();

        // Reset asserted in the middle of the HI phase of a write
        issue(1'b1, 17'h00040, 4'hF, 32'hCAFEF00D);
        cyc();
        check("rm_hi_active", {chip_en, wre}, 2'b00);
        #1 reset = 1'b0;
        #1;
        check("rm_strobes", {chip_en, wre, oute, hb_mask, lb_mask}, 5'b11111);
        check("rm_data_z", data, 16'hFFFF);
        check("rm_ready", ready, 0);
        check("rm_addr", addr, 0);
        check("rm_rdata", cpu_rdata, 0);
        cyc();
        cyc();
        check("rm_ready_held", ready, 0);
        reset = 1'b1;
        issue(1'b0, 17'h00012, 4'hF, 32'h0);
        check("rm_lo_addr", addr, 18'h00024);
        cyc();
        cyc();
        check("rm_done_ready", ready, 1);
        check("rm_rdata_after", cpu_rdata, 32'hDEADBEEF);
        cyc();
        check("ready_pulses", ready_pulses, 6);

        // WAIT_CYCLES=3 read with req held high across completion
        we3 = 1'b0; cpu_addr3 = 17'h00012; cpu_be3 = 4'hF; req3 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c <= 3) begin
                check($sformatf("w3_lo_c%0d", c), {oute3, ready3, addr3}, {2'b00, 18'h00024});
            end else if (c <= 6) begin
                check($sformatf("w3_hi_c%0d", c), {oute3, ready3, addr3}, {2'b00, 18'h00025});
            end else if (c == 7) begin
                check("w3_done_ready", ready3, 1);
                check("w3_done_rdata", cpu_rdata3, 32'h22221111);
            end else if (c == 8) begin
                check("w3_gap_idle", {chip_en3, ready3}, 2'b10);
            end else begin
                check("w3_second_lo", {chip_en3, oute3, addr3}, {2'b00, 18'h00024});
            end
        end
        req3 = 1'b0;
        for (int c = 0; c < 8; c++) cyc();
        check("w3_second_rdata", cpu_rdata3, 32'h22221111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
